// File: rtl/calendar_pkg.sv
// Shared calendar constants: month numbers and Gregorian month lengths.
package calendar_pkg;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    localparam int unsigned NUM_GREG_MONTHS = 12;
    localparam int unsigned FEB_LEAP_DAYS   = 29;

    // Entry 0 is January; February holds the common-year length.
    localparam logic [4:0] DIM_TABLE [NUM_GREG_MONTHS] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

endpackage

// File: rtl/calendar_counter_days_in_month.sv
// Combinational days-in-month lookup; February follows `leap` only when LEAP_YEAR_EN is defined.
module days_in_month
    import calendar_pkg::*;
#(
    parameter int DAY_W      = 5,
    parameter int MON_W      = 4,
    parameter int MONTH_DAYS = 0
) (
    input  logic [MON_W-1:0] month,
    input  logic             leap,
    output logic [DAY_W-1:0] dim
);

    if (MONTH_DAYS != 0) begin : g_uniform
        logic unused_inputs;
        assign unused_inputs = ^{month, leap};
        assign dim = DAY_W'(MONTH_DAYS);
    end else begin : g_table
`ifndef LEAP_YEAR_EN
        logic unused_leap;
        assign unused_leap = leap;
`endif
        // Out-of-range months yield 0 so any load check against them fails.
        always_comb begin
            dim = '0;
            for (int unsigned i = 0; i < NUM_GREG_MONTHS; i++) begin
                if (month == MON_W'(i + 1)) begin
                    dim = DAY_W'(DIM_TABLE[i[3:0]]);
                end
            end
`ifdef LEAP_YEAR_EN
            if (month == MON_W'(FEB) && leap) begin
                dim = DAY_W'(FEB_LEAP_DAYS);
            end
`endif
        end
    end

endmodule

// File: rtl/calendar_counter.sv
// Day/month calendar counter with validated loads and year carry.
// Optional macro LEAP_YEAR_EN: February length follows the `leap` input.
module calendar_counter
    import calendar_pkg::*;
#(
    parameter int DAY_W      = 5,
    parameter int MON_W      = 4,
    parameter int MONTHS     = 12,
    parameter int MONTH_DAYS = 0,
    localparam int DATA_W    = (DAY_W > MON_W) ? DAY_W : MON_W
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   tick,
    input  logic                   load,
    input  logic                   load_sel,
    input  logic [DATA_W-1:0]      data,
    input  logic                   enable,
    input  logic                   leap,
    output logic [DAY_W-1:0]       day,
    output logic [MON_W-1:0]       month,
    output logic [MON_W+DAY_W-1:0] databus,
    output logic                   year_carry,
    output logic                   load_err
);

    localparam logic [DAY_W-1:0] DAY_ONE  = DAY_W'(1);
    localparam logic [MON_W-1:0] MON_ONE  = MON_W'(1);
    localparam logic [MON_W-1:0] MON_LAST = MON_W'(MONTHS);

    logic [DAY_W-1:0] data_day;
    logic [MON_W-1:0] data_mon;
    logic [DAY_W-1:0] dim_cur;
    logic [DAY_W-1:0] dim_new;
    logic [DAY_W-1:0] day_n;
    logic [MON_W-1:0] month_n;
    logic             carry_n;
    logic             err_n;

    assign data_day = data[DAY_W-1:0];
    assign data_mon = data[MON_W-1:0];

    days_in_month #(.DAY_W(DAY_W), .MON_W(MON_W), .MONTH_DAYS(MONTH_DAYS)) u_dim_cur (
        .month (month),
        .leap  (leap),
        .dim   (dim_cur)
    );

    // Length of the month being loaded, for validation and day clamping.
    days_in_month #(.DAY_W(DAY_W), .MON_W(MON_W), .MONTH_DAYS(MONTH_DAYS)) u_dim_new (
        .month (data_mon),
        .leap  (leap),
        .dim   (dim_new)
    );

    always_comb begin
        day_n   = day;
        month_n = month;
        carry_n = 1'b0;
        err_n   = 1'b0;
        if (load) begin
            if (!load_sel) begin
                if (data_day >= DAY_ONE && data_day <= dim_cur) begin
                    day_n = data_day;
                end else begin
                    err_n = 1'b1;
                end
            end else begin
                if (data_mon >= MON_ONE && data_mon <= MON_LAST) begin
                    month_n = data_mon;
                    if (day > dim_new) begin
                        day_n = dim_new;
                    end
                end else begin
                    err_n = 1'b1;
                end
            end
        end else if (tick) begin
            // >= also rolls a stale 29 Feb after leap drops.
            if (day >= dim_cur) begin
                day_n = DAY_ONE;
                if (month == MON_LAST) begin
                    month_n = MON_ONE;
                    carry_n = 1'b1;
                end else begin
                    month_n = month + MON_ONE;
                end
            end else begin
                day_n = day + DAY_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            day        <= DAY_ONE;
            month      <= MON_ONE;
            year_carry <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            day        <= day_n;
            month      <= month_n;
            year_carry <= carry_n;
            load_err   <= err_n;
        end
    end

    assign databus = {month, day} & {(MON_W + DAY_W){enable}};

endmodule

// File: tb/tb_calendar_counter.sv
// Self-checking bench: Gregorian and 30-day-month instances against a calendar reference model.
module tb_calendar_counter;

    logic       clk = 1'b0;
    logic       clear;
    logic       tick;
    logic       load;
    logic       load_sel;
    logic [4:0] data;
    logic       enable;
    logic       leap;

    logic [4:0] day_g, day_u;
    logic [3:0] mon_g, mon_u;
    logic [8:0] bus_g, bus_u;
    logic       carry_g, carry_u, err_g, err_u;

    int total = 0;
    int bad   = 0;

    int m_day[2];
    int m_mon[2];
    int m_carry[2];
    int m_err[2];

    always #5 clk = ~clk;

    calendar_counter dut_g (
        .clk(clk), .clear(clear), .tick(tick), .load(load), .load_sel(load_sel),
        .data(data), .enable(enable), .leap(leap), .day(day_g), .month(mon_g),
        .databus(bus_g), .year_carry(carry_g), .load_err(err_g)
    );

    calendar_counter #(.MONTH_DAYS(30)) dut_u (
        .clk(clk), .clear(clear), .tick(tick), .load(load), .load_sel(load_sel),
        .data(data), .enable(enable), .leap(leap), .day(day_u), .month(mon_u),
        .databus(bus_u), .year_carry(carry_u), .load_err(err_u)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_dim(input int cfg, input int mon, input bit lp);
        int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mon < 1 || mon > 12) return 0;
        if (cfg == 1) return 30;
`ifdef LEAP_YEAR_EN
        if (mon == 2 && lp) return 29;
`endif
        return lens[mon - 1];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_day[c] = 1; m_mon[c] = 1; m_carry[c] = 0; m_err[c] = 0;
        end
    endtask

    task automatic check_all();
        int exp_g, exp_u;
        check("g_day",   int'(day_g),   m_day[0]);
        check("g_month", int'(mon_g),   m_mon[0]);
        check("g_carry", int'(carry_g), m_carry[0]);
        check("g_err",   int'(err_g),   m_err[0]);
        check("u_day",   int'(day_u),   m_day[1]);
        check("u_month", int'(mon_u),   m_mon[1]);
        check("u_carry", int'(carry_u), m_carry[1]);
        check("u_err",   int'(err_u),   m_err[1]);
        exp_g = enable ? m_mon[0] * 32 + m_day[0] : 0;
        exp_u = enable ? m_mon[1] * 32 + m_day[1] : 0;
        check("g_bus", int'(bus_g), exp_g);
        check("u_bus", int'(bus_u), exp_u);
    endtask

    // Apply one clock of inputs, advance the calendar model by its rules, then compare.
    task automatic step(input bit t, input bit l, input bit ls, input int d, input bit lp);
        int nd[2], nm[2], nc[2], ne[2];
        int dim, mv, dv, nlen;
        tick = t; load = l; load_sel = ls; leap = lp;
        data = 5'(d);
        mv = d % 16;
        dv = d % 32;
        for (int c = 0; c < 2; c++) begin
            nd[c] = m_day[c]; nm[c] = m_mon[c]; nc[c] = 0; ne[c] = 0;
            dim = ref_dim(c, m_mon[c], lp);
            if (l) begin
                if (!ls) begin
                    if (dv >= 1 && dv <= dim) nd[c] = dv;
                    else ne[c] = 1;
                end else begin
                    if (mv >= 1 && mv <= 12) begin
                        nm[c] = mv;
                        nlen = ref_dim(c, mv, lp);
                        if (m_day[c] > nlen) nd[c] = nlen;
                    end else begin
                        ne[c] = 1;
                    end
                end
            end else if (t) begin
                if (m_day[c] >= dim) begin
                    nd[c] = 1;
                    if (m_mon[c] == 12) begin
                        nm[c] = 1; nc[c] = 1;
                    end else begin
                        nm[c] = m_mon[c] + 1;
                    end
                end else begin
                    nd[c] = m_day[c] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            m_day[c] = nd[c]; m_mon[c] = nm[c]; m_carry[c] = nc[c]; m_err[c] = ne[c];
        end
        check_all();
    endtask

    initial begin
        clear = 1'b1; tick = 0; load = 0; load_sel = 0; data = '0; enable = 1'b1; leap = 0;
        model_reset();
        #12;
        check_all();
        clear = 1'b0;

        // Reach 17 May, then clear asynchronously mid-cycle.
        step(0, 1, 1, 5, 0);
        step(0, 1, 0, 17, 0);
        #2;
        clear = 1'b1;
        enable = 1'b0;
        #1;
        model_reset();
        check("clr_day", int'(day_g), 1);
        check("clr_month", int'(mon_g), 1);
        check("clr_bus_off", int'(bus_g), 0);
        enable = 1'b1;
        #1;
        check("clr_bus_on", int'(bus_g), 'h021);
        clear = 1'b0;

        // Year wrap, carry only one cycle.
        step(0, 1, 1, 12, 0);
        step(0, 1, 0, 31, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // February with and without leap.
        step(0, 1, 1, 2, 1);
        step(0, 1, 0, 28, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 1, 1, 2, 0);
        step(0, 1, 0, 28, 0);
        step(1, 0, 0, 0, 0);
        // Leap drops while sitting on 29 Feb.
        step(0, 1, 1, 2, 1);
        step(0, 1, 0, 29, 1);
        step(1, 0, 0, 0, 0);

        // Clamp on month load and rejected loads.
        step(0, 1, 1, 1, 0);
        step(0, 1, 0, 31, 0);
        step(0, 1, 1, 4, 0);
        step(0, 1, 0, 31, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 13, 0);
        step(0, 1, 0, 0, 0);

        // 30 Jul rollover.
        step(0, 1, 1, 7, 0);
        step(0, 1, 0, 30, 0);
        step(1, 0, 0, 0, 0);

        // Load beats tick; held tick advances every clock.
        step(0, 1, 0, 5, 0);
        step(1, 1, 0, 10, 0);
        step(0, 1, 0, 5, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            enable = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calendar_counter.md
Name: calendar_counter

Overview:
- Day-of-month and month counter for the clock/calendar datapath. Generalised successor to the fixed-length day counter.
- Advances one day per `tick` strobe, which comes from the hour counter's rollover.
- Month length is either Gregorian (with leap support) or a uniform parameterised length.
- Pulses `year_carry` on December→January wrap, for the year counter.
- Supports validated loading of day or month, and an enable-gated output bus for the display mux.

Parameters:
- DAY_W, 5, width of day register (must hold max month length).
- MON_W, 4, width of month register (must hold MONTHS).
- MONTHS, 12, months per year. Must be 12 when MONTH_DAYS=0.
- MONTH_DAYS, 0. 0 = Gregorian table (31,28/29,31,30,31,30,31,31,30,31,30,31); nonzero = every month has this many days (e.g. 30).

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- tick  in  1  advance one day; single-cycle strobe.
- load  in  1  synchronous load request.
- load_sel  in  1  0 = load day, 1 = load month.
- data  in  max(DAY_W,MON_W)  load value; low bits used for the selected field.
- enable  in  1  output bus enable.
- leap  in  1  current year is leap (from year counter).
- day  out  DAY_W  current day, 1-based.
- month  out  MON_W  current month, 1-based.
- databus  out  MON_W+DAY_W  {month,day} when enable=1, else all zeros (combinational AND gating).
- year_carry  out  1  one-cycle pulse on year wrap.
- load_err  out  1  one-cycle pulse on a rejected load.

Behaviour:
- Reset: `clear` high asynchronously forces day=1, month=1, year_carry=0, load_err=0. Release takes effect at the next clk edge; no tick is lost or generated.
- `dim` = days-in-month of the current month (from the table, or MONTH_DAYS). In Gregorian mode February = 29 if leap else 28.
- Priority per edge: load > tick. A tick coinciding with a load is dropped; the load result stands.
- Tick:
  - if day >= dim: day←1.
  - then if month == MONTHS: month←1 and year_carry←1 for exactly the next cycle; else month←month+1.
  - otherwise day←day+1.
  - Using >= (not ==) covers `leap` falling while day=29 Feb: the next tick goes to 1 Mar.
- Load day (load_sel=0):
  - accept if 1 ≤ data ≤ dim(current month); day←data, month unchanged.
  - otherwise no state change, load_err=1 next cycle.
- Load month (load_sel=1):
  - accept if 1 ≤ data ≤ MONTHS; month←data.
  - if current day > dim(new month), day←dim(new month) (clamp).
  - otherwise no state change, load_err=1.
- Timing: outputs are registered except `databus`. Latency is one clk from a tick or load to the updated day/month.
- Pulses: year_carry and load_err are registered single-cycle pulses. They are cleared the following cycle unless retriggered.
- `tick` held high advances once per clk (no edge detection; the upstream block guarantees a strobe).

Optional Feature:
- Macro LEAP_YEAR_EN.
- Defined: Gregorian February length follows `leap` as above.
- Undefined: February is always 28; `leap` is ignored (port kept, unused).
- No effect when MONTH_DAYS≠0.

Decomposition:
- Package calendar_pkg holds:
  - month-number constants JAN..DEC;
  - the 12-entry days-in-month constant array;
  - the February leap length (29).
- Sub-module `days_in_month`: combinational lookup (month, leap) → dim, parameterised by MONTH_DAYS.
- It is instantiated twice: once for the current month and once for load data (clamp/validate).

Test Plan:
- Pulse `clear` mid-count at day=17, month=5 → immediately day=1, month=1; databus=0 with enable=0 and 0x021 with enable=1.
- Load month=12, day=31, then tick → day=1, month=1, year_carry=1 for one cycle only.
- Gregorian with LEAP_YEAR_EN, leap=1, month=2, day=28: tick → 29; tick → 1, month=3. Repeat with leap=0: 28 → 1 Mar. Without the macro, leap=1: 28 → 1 Mar.
- At day=31 month=1, load month=4 → month=4, day=30. Load day=31 → rejected, load_err pulse, day stays 30. Load month=0 or 13 → load_err, no change.
- MONTH_DAYS=30: load day=30 month=7, tick → day=1 month=8. Load day=31 → load_err.
- load and tick in the same cycle with data=10, load_sel=0 → day=10 (tick dropped). Tick held for 3 clks from day=5 → day=8.
